// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: E-stage multiply/divide bus between the pipeline and the MDU.
//   master modport: pipeline side (drives start/op/mt writes/operands/isMDFT_D,
//                   receives HI/LO/Busy/Stall)
//   slave modport : MDU side (the reverse)
interface mdu_sequencer_if;
  logic        MDU_Start;     // mult/multu/div/divu valid, one-cycle pulse
  logic [2:0]  MDU_Op;        // 0 mult, 1 multu, 2 div, 3 divu, 4..7 mult
  logic        MDU_HI_Write;  // mthi in E stage
  logic        MDU_LO_Write;  // mtlo in E stage
  logic [31:0] A;             // forwarded rs
  logic [31:0] B;             // forwarded rt
  logic        isMDFT_D;      // D-stage instruction is md/mf/mt class
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Stall;

  modport master (
    output MDU_Start, MDU_Op, MDU_HI_Write, MDU_LO_Write, A, B, isMDFT_D,
    input  HI, LO, Busy, Stall
  );

  modport slave (
    input  MDU_Start, MDU_Op, MDU_HI_Write, MDU_LO_Write, A, B, isMDFT_D,
    output HI, LO, Busy, Stall
  );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide unit with HI/LO registers and
// D-stage stall generation, modelling MIPS mult/multu/div/divu latency.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high reset
//   mdu   - mdu_sequencer_if.slave (start/op/mt writes/operands/isMDFT_D in,
//           HI/LO/Busy/Stall out)
// Parameters: MULT_CYCLES (busy cycles for mult/multu), DIV_CYCLES (div/divu).
// Optional feature macro: MDU_DIV0_FAST_EN - a divide by zero finishes after a
// single busy cycle instead of DIV_CYCLES. HI/LO are left unchanged either way.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic               clk,
  input logic               reset,
  mdu_sequencer_if.slave    mdu
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_wr;   // cleared for divide by zero: HI/LO keep their value

  logic             w_is_div;
  logic             w_is_uns;
  logic             w_div0;
  logic [63:0]      w_ea;
  logic [63:0]      w_eb;
  logic [63:0]      w_prod;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [31:0]      w_a_mag;
  logic [31:0]      w_b_mag;
  logic [31:0]      w_q_mag;
  logic [31:0]      w_r_mag;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;
  logic [CNT_W-1:0] w_cycles;
  logic             w_busy;

  // Result datapath evaluated on the start edge.
  always_comb begin
    w_is_div = (mdu.MDU_Op == 3'd2) || (mdu.MDU_Op == 3'd3);
    w_is_uns = (mdu.MDU_Op == 3'd1) || (mdu.MDU_Op == 3'd3);
    w_div0   = w_is_div && (mdu.B == 32'd0);

    // Sign/zero extension to 64 bits makes one unsigned multiply serve both forms.
    w_ea   = w_is_uns ? {32'd0, mdu.A} : {{32{mdu.A[31]}}, mdu.A};
    w_eb   = w_is_uns ? {32'd0, mdu.B} : {{32{mdu.B[31]}}, mdu.B};
    w_prod = w_ea * w_eb;

    // Signed divide via magnitudes: quotient truncates toward zero,
    // remainder takes the dividend's sign. Divisor forced to 1 on B==0 to keep X out.
    w_a_neg = !w_is_uns && mdu.A[31];
    w_b_neg = !w_is_uns && mdu.B[31];
    w_a_mag = w_a_neg ? (32'd0 - mdu.A) : mdu.A;
    w_b_mag = w_div0 ? 32'd1 : (w_b_neg ? (32'd0 - mdu.B) : mdu.B);
    w_q_mag = w_a_mag / w_b_mag;
    w_r_mag = w_a_mag % w_b_mag;
    w_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

`ifdef MDU_DIV0_FAST_EN
    w_cycles = w_div0   ? CNT_W'(1) :
               w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`else
    w_cycles = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`endif
  end

  // Sequencer FSM, HI/LO and pending-result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdu.MDU_Start) begin
            // Start wins over a same-cycle mthi/mtlo.
            r_pend_hi <= w_is_div ? w_rem : w_prod[63:32];
            r_pend_lo <= w_is_div ? w_quo : w_prod[31:0];
            r_pend_wr <= !w_div0;
            r_cnt     <= w_cycles;
            r_state   <= S_RUN;
          end else begin
            if (mdu.MDU_HI_Write) r_hi <= mdu.A;
            if (mdu.MDU_LO_Write) r_lo <= mdu.A;
          end
        end
        S_RUN: begin
          // Starts and mt writes arriving while busy are dropped.
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy    = (r_state == S_RUN);
  assign mdu.Busy  = w_busy;
  assign mdu.HI    = r_hi;
  assign mdu.LO    = r_lo;
  // Combinational so the start cycle itself already holds the dependent D-stage op.
  assign mdu.Stall = mdu.isMDFT_D & (w_busy | mdu.MDU_Start);

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed literal checks plus randomized traffic compared
// every cycle against a completion-time based reference model.
module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;

  mdu_sequencer_if bus ();

  mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int stall_cnt = 0;

  // Reference model: result and the edge number at which it lands.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_active, m_wr;
  longint      m_edge, m_end;

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb, q, r;
    longint p;
    logic [63:0] u;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd2: begin q = sa / sb; r = sa % sb; return {32'(r), 32'(q)}; end
      3'd3: return {a % b, a / b};
      3'd1: begin u = {32'd0, a} * {32'd0, b}; return u; end
      default: begin p = longint'(sa) * longint'(sb); return 64'(p); end
    endcase
  endfunction

  task automatic model_edge();
    logic [63:0] res;
    bit          is_div;
    longint      dur;
    m_edge++;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_active = 0; m_wr = 0;
    end else if (m_active) begin
      if (m_edge == m_end) begin
        m_active = 0;
        if (m_wr) begin m_hi = m_phi; m_lo = m_plo; end
      end
    end else if (bus.MDU_Start) begin
      is_div = (bus.MDU_Op == 3'd2) || (bus.MDU_Op == 3'd3);
      m_wr   = !(is_div && bus.B == 32'd0);
      if (m_wr) begin
        res = ref_result(bus.MDU_Op, bus.A, bus.B);
        m_phi = res[63:32];
        m_plo = res[31:0];
      end
      dur = is_div ? DIV_N : MULT_N;
`ifdef MDU_DIV0_FAST_EN
      if (!m_wr) dur = 1;
`endif
      m_end = m_edge + dur;
      m_active = 1;
    end else begin
      if (bus.MDU_HI_Write) m_hi = bus.A;
      if (bus.MDU_LO_Write) m_lo = bus.A;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare();
    logic exp_stall;
    exp_stall = bus.isMDFT_D & (m_active | bus.MDU_Start);
    chk("model_HI", bus.HI, m_hi);
    chk("model_LO", bus.LO, m_lo);
    chk("model_Busy", 32'(bus.Busy), 32'(m_active));
    chk("model_Stall", 32'(bus.Stall), 32'(exp_stall));
  endtask

  // One clock: check settled outputs, take the edge, update the model.
  task automatic step();
    #1;
    if (chk_en) compare();
    if (bus.Stall === 1'b1) stall_cnt++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.MDU_Start = 0; bus.MDU_HI_Write = 0; bus.MDU_LO_Write = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDU_Start = 1; bus.MDU_Op = op; bus.A = a; bus.B = b;
    step();
    idle_inputs();
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.Busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: Busy still high after %0d cycles", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    m_edge = 0; m_end = 0; m_active = 0; m_wr = 0;
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    reset = 1;
    bus.MDU_Op = 3'd0; bus.A = '0; bus.B = '0; bus.isMDFT_D = 0;
    idle_inputs();
    step();
    chk_en = 1;
    step();
    reset = 0;

    chk("reset_HI", bus.HI, 32'h0);
    chk("reset_LO", bus.LO, 32'h0);
    chk("reset_Busy", 32'(bus.Busy), 32'd0);

    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("mult_busy_len", n, 32'd5);
    chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bus.LO, 32'hFFFF_FFFE);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_busy_len", n, 32'd5);
    chk("multu_HI", bus.HI, 32'h0000_0001);
    chk("multu_LO", bus.LO, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_len", n, 32'd10);
    chk("div_LO", bus.LO, 32'hFFFF_FFFD);
    chk("div_HI", bus.HI, 32'hFFFF_FFFF);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("divu_LO", bus.LO, 32'h7FFF_FFFC);
    chk("divu_HI", bus.HI, 32'h0000_0001);

    bus.MDU_HI_Write = 1; bus.A = 32'h1234;
    step();
    idle_inputs();
    chk("mthi_idle", bus.HI, 32'h1234);

    issue(3'd0, 32'd3, 32'd4);
    bus.MDU_LO_Write = 1; bus.A = 32'hDEAD;
    step();
    idle_inputs();
    chk("mtlo_busy_dropped", bus.LO, 32'h7FFF_FFFC);
    wait_idle(n);
    chk("mult_3x4_LO", bus.LO, 32'd12);

    bus.MDU_HI_Write = 1;
    issue(3'd0, 32'h10, 32'h10);
    wait_idle(n);
    chk("start_beats_mthi_HI", bus.HI, 32'h0);
    chk("start_beats_mthi_LO", bus.LO, 32'h100);

    stall_cnt = 0;
    bus.isMDFT_D = 1;
    issue(3'd0, 32'd7, 32'd6);
    wait_idle(n);
    step();
    bus.isMDFT_D = 0;
    chk("stall_cycles", stall_cnt, 32'd6);
    chk("mflo_sees_new_LO", bus.LO, 32'd42);

    bus.MDU_HI_Write = 1; bus.A = 32'hAA;
    step();
    bus.MDU_HI_Write = 0; bus.MDU_LO_Write = 1; bus.A = 32'hBB;
    step();
    idle_inputs();
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(n);
`ifdef MDU_DIV0_FAST_EN
    chk("div0_busy_len", n, 32'd1);
`else
    chk("div0_busy_len", n, 32'd10);
`endif
    chk("div0_HI", bus.HI, 32'hAA);
    chk("div0_LO", bus.LO, 32'hBB);

    issue(3'd2, 32'd100, 32'd7);
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    chk("abort_HI", bus.HI, 32'h0);
    chk("abort_LO", bus.LO, 32'h0);
    chk("abort_Busy", 32'(bus.Busy), 32'd0);

    // Randomized traffic, including starts/mt writes while busy and rare resets.
    for (int i = 0; i < 600; i++) begin
      reset            = ($urandom_range(0, 149) == 0);
      bus.MDU_Start    = ($urandom_range(0, 4) == 0);
      bus.MDU_Op       = 3'($urandom_range(0, 7));
      bus.A            = pick();
      bus.B            = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      bus.isMDFT_D     = $urandom_range(0, 1) == 1;
      bus.MDU_HI_Write = ($urandom_range(0, 5) == 0);
      bus.MDU_LO_Write = ($urandom_range(0, 5) == 0);
      if (bus.MDU_Op == 3'd2 && bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF)
        bus.B = 32'd1;
      step();
    end
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 15; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
